// File: rtl/conv_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared constants, data types and state encoding for the
//               5x5, 3-channel convolution sequencer.
// Contents    : TAPS/KW/LINE_W/DATA_W/CNT_W, PRIME_PX, coef_t, pixel_t,
//               seq_state_t
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int TAPS     = 25;                 // coefficients per kernel
    localparam int KW       = 5;                  // kernel width
    localparam int LINE_W   = 45;                 // line-buffer depth
    localparam int DATA_W   = 8;                  // coefficient/channel width
    localparam int CNT_W    = 16;                 // window counter width
    localparam int PRIME_PX = (KW - 1) * LINE_W;  // pixels to fill line buffers

    localparam int TAP_W    = 5;                  // holds 0..TAPS-1
    localparam int SEL_W    = 3;                  // holds 0..KW-1
    localparam int PX_CNT_W = 8;                  // holds 0..PRIME_PX

    typedef logic [DATA_W-1:0]      coef_t;
    typedef logic [2:0][DATA_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_PRIME = 3'd2,
        S_FETCH = 3'd3,
        S_SWEEP = 3'd4,
        S_OUT   = 3'd5,
        S_FIN   = 3'd6
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/conv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_seq_if
// Description : Handshake and datapath bundle between the convolution
//               sequencer and its environment (job control, coefficient
//               stream, DDR pixel stream, conv channels, DDR result sink).
// Modports    : master - the sequencer; slave - the surrounding system
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_seq_if;
    import conv_pkg::*;

    logic                   start;
    logic [CNT_W-1:0]       num_windows;
    logic                   kcoef_valid;
    coef_t                  kcoef_data;
    logic                   kcoef_ready;
    logic                   px_valid;
    pixel_t                 px_data;
    logic                   px_ready;
    logic                   buf_shift;
    pixel_t                 buf_data;
    logic [TAP_W-1:0]       tap_idx;
    logic [SEL_W-1:0]       select_idx;
    coef_t                  conv_val;
    logic                   acc_clear;
    logic                   acc_en;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;
    logic                   done;

    modport master (
        input  start, num_windows, kcoef_valid, kcoef_data, px_valid, px_data,
               out_ready,
        output kcoef_ready, px_ready, buf_shift, buf_data, tap_idx, select_idx,
               conv_val, acc_clear, acc_en, out_valid, busy, done
    );

    modport slave (
        output start, num_windows, kcoef_valid, kcoef_data, px_valid, px_data,
               out_ready,
        input  kcoef_ready, px_ready, buf_shift, buf_data, tap_idx, select_idx,
               conv_val, acc_clear, acc_en, out_valid, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/conv_sequencer_tap_counter.sv
`default_nettype none
// ============================================================================
// Module      : tap_counter
// Description : Kernel tap counter 0..TAPS-1 with a companion row select
//               that wraps at KW. Wraps to 0 after the last tap.
// Ports       : CLK, reset   - clock, synchronous active-high reset
//               clear        - force tap/select to 0
//               advance      - step to the next tap
//               tap_idx      - current tap
//               select_idx   - tap_idx mod KW
//               last         - current tap is TAPS-1
// Revision    : 1.0 - initial release
// ============================================================================
module tap_counter
    import conv_pkg::*;
(
    input  wire logic             CLK,
    input  wire logic             reset,
    input  wire logic             clear,
    input  wire logic             advance,
    output logic [TAP_W-1:0]      tap_idx,
    output logic [SEL_W-1:0]      select_idx,
    output logic                  last
);

    localparam logic [TAP_W-1:0] c_TAP_LAST = TAP_W'(TAPS - 1);
    localparam logic [SEL_W-1:0] c_SEL_LAST = SEL_W'(KW - 1);

    logic [TAP_W-1:0] r_tap;
    logic [SEL_W-1:0] r_sel;

    // Select is kept as its own wrapping counter rather than a modulo of tap.
    always_ff @(posedge CLK) begin
        if (reset || clear) begin
            r_tap <= '0;
            r_sel <= '0;
        end else if (advance) begin
            r_tap <= (r_tap == c_TAP_LAST) ? '0 : r_tap + 1'b1;
            r_sel <= (r_sel == c_SEL_LAST) ? '0 : r_sel + 1'b1;
        end
    end

    assign tap_idx    = r_tap;
    assign select_idx = r_sel;
    assign last       = (r_tap == c_TAP_LAST);

endmodule
`default_nettype wire

// File: rtl/conv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : conv_sequencer
// Description : Sequences the 5x5, 3-channel convolution datapath: loads the
//               kernel bank, primes the line buffers, then runs one 25-cycle
//               tap sweep per output window and hands each result to the DDR
//               write shift register.
// Ports       : CLK    - system clock
//               reset  - synchronous active-high reset (aborts any job)
//               bus    - conv_seq_if.master: job control, coefficient and
//                        pixel streams, tap/accumulator controls, result
//                        handshake, busy/done status
// Revision    : 1.0 - initial release
// ============================================================================
module conv_sequencer
    import conv_pkg::*;
(
    input  wire logic     CLK,
    input  wire logic     reset,
    conv_seq_if.master    bus
);

    localparam logic [TAP_W-1:0]    c_KCNT_LAST  = TAP_W'(TAPS - 1);
    localparam logic [PX_CNT_W-1:0] c_PRIME_LAST = PX_CNT_W'(PRIME_PX - 1);
    localparam logic [CNT_W-1:0]    c_ONE_LEFT   = CNT_W'(1);

    seq_state_t          r_state;
    seq_state_t          w_state_next;
    coef_t               r_kernel [TAPS];
    logic [TAP_W-1:0]    r_kcnt;
    logic [PX_CNT_W-1:0] r_pxcnt;
    logic [CNT_W-1:0]    r_remaining;

    logic                w_kc_hs;
    logic                w_px_hs;
    logic                w_out_hs;
    logic                w_in_sweep;
    logic [TAP_W-1:0]    w_tap;
    logic [SEL_W-1:0]    w_sel;
    logic                w_tap_last;

    assign w_in_sweep = (r_state == S_SWEEP);
    assign w_kc_hs    = (r_state == S_LOAD) && bus.kcoef_valid;
    assign w_px_hs    = ((r_state == S_PRIME) || (r_state == S_FETCH)) && bus.px_valid;
    assign w_out_hs   = (r_state == S_OUT) && bus.out_ready;

    // Held at 0 outside SWEEP so every sweep starts on tap 0.
    tap_counter u_tap_counter (
        .CLK        (CLK),
        .reset      (reset),
        .clear      (!w_in_sweep),
        .advance    (w_in_sweep),
        .tap_idx    (w_tap),
        .select_idx (w_sel),
        .last       (w_tap_last)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_kcnt      <= '0;
            r_pxcnt     <= '0;
            r_remaining <= '0;
            for (int i = 0; i < TAPS; i++) begin
                r_kernel[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            if ((r_state == S_IDLE) && bus.start) begin
                r_remaining <= bus.num_windows;
                r_kcnt      <= '0;
                r_pxcnt     <= '0;
            end
            if (w_kc_hs) begin
                r_kernel[r_kcnt] <= bus.kcoef_data;
                r_kcnt           <= r_kcnt + 1'b1;
            end
            if (w_px_hs && (r_state == S_PRIME)) begin
                r_pxcnt <= r_pxcnt + 1'b1;
            end
            if (w_out_hs) begin
                r_remaining <= r_remaining - 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        bus.kcoef_ready = 1'b0;
        bus.px_ready    = 1'b0;
        bus.buf_shift   = 1'b0;
        bus.buf_data    = '0;
        bus.tap_idx     = '0;
        bus.select_idx  = '0;
        bus.conv_val    = '0;
        bus.acc_clear   = 1'b0;
        bus.acc_en      = 1'b0;
        bus.out_valid   = 1'b0;
        bus.done        = 1'b0;
        bus.busy        = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                bus.kcoef_ready = 1'b1;
                if (w_kc_hs && (r_kcnt == c_KCNT_LAST)) w_state_next = S_PRIME;
            end
            S_PRIME: begin
                bus.px_ready  = 1'b1;
                bus.buf_shift = bus.px_valid;
                bus.buf_data  = bus.px_data;
                if (w_px_hs && (r_pxcnt == c_PRIME_LAST)) begin
                    w_state_next = (r_remaining == '0) ? S_FIN : S_FETCH;
                end
            end
            S_FETCH: begin
                bus.px_ready  = 1'b1;
                bus.buf_shift = bus.px_valid;
                bus.buf_data  = bus.px_data;
                if (w_px_hs) w_state_next = S_SWEEP;
            end
            S_SWEEP: begin
                bus.tap_idx    = w_tap;
                bus.select_idx = w_sel;
                bus.conv_val   = r_kernel[w_tap];
                bus.acc_en     = 1'b1;
                bus.acc_clear  = (w_tap == '0);
                if (w_tap_last) w_state_next = S_OUT;
            end
            S_OUT: begin
                bus.out_valid = 1'b1;
                // Decision uses the pre-decrement count: one left means this
                // handshake finishes the job.
                if (w_out_hs) begin
                    w_state_next = (r_remaining == c_ONE_LEFT) ? S_FIN : S_FETCH;
                end
            end
            S_FIN: begin
                bus.done     = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_sequencer
// Description : Self-checking bench for conv_sequencer. Each job is walked
//               phase by phase (load, prime, per-window fetch/sweep/out,
//               finish) with random stream gaps, random kernels and pixels,
//               and every observed output is compared to values derived from
//               the job description.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_sequencer;
    import conv_pkg::*;

    logic CLK;
    logic reset;
    int   total;
    int   bad;

    conv_seq_if bus ();

    conv_sequencer dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.kcoef_ready !== 1'b0 ||
            bus.px_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.acc_en !== 1'b0 ||
            bus.acc_clear !== 1'b0 || bus.tap_idx !== '0 || bus.conv_val !== '0 ||
            bus.buf_shift !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b kr=%b pr=%b ov=%b ae=%b tap=%0d required all 0",
                     bus.busy, bus.done, bus.kcoef_ready, bus.px_ready, bus.out_valid,
                     bus.acc_en, bus.tap_idx);
        end
    endtask

    // Runs one complete job and checks it against the expected phase sequence.
    task automatic run_job(input int nwin, input bit gaps, input int stall,
                           input bit start_in_prime, input bit seq_kernel);
        coef_t kern [TAPS];
        int    k, cyc, shifts, wcyc, prev_hs;
        bit    got;

        for (int i = 0; i < TAPS; i++)
            kern[i] = seq_kernel ? DATA_W'(i + 1) : DATA_W'($urandom);

        bus.start       = 1'b1;
        bus.num_windows = CNT_W'(nwin);
        tick();
        bus.start       = 1'b0;
        bus.num_windows = CNT_W'($urandom);
        #1;
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL start_busy: got %b want 1", bus.busy);
        end

        // Kernel load
        k = 0; cyc = 0;
        while (k < TAPS && cyc < 1000) begin
            bus.kcoef_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.kcoef_data  = kern[k];
            #1;
            total++;
            if (bus.kcoef_ready !== 1'b1 || bus.px_ready !== 1'b0) begin
                bad++;
                $display("FAIL load_ready: kr=%b pr=%b after %0d coefs want kr=1 pr=0",
                         bus.kcoef_ready, bus.px_ready, k);
                break;
            end
            if (bus.kcoef_valid) k++;
            tick();
            cyc++;
        end
        bus.kcoef_valid = 1'b1;
        #1;
        total++;
        if (k != TAPS || bus.kcoef_ready !== 1'b0 || bus.px_ready !== 1'b1) begin
            bad++;
            $display("FAIL load_end: coefs=%0d kr=%b pr=%b want %0d,0,1",
                     k, bus.kcoef_ready, bus.px_ready, TAPS);
        end
        bus.kcoef_valid = 1'b0;

        // Line-buffer prime
        shifts = 0; cyc = 0;
        while (shifts < PRIME_PX && cyc < 2000) begin
            bus.px_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.px_data  = 24'($urandom);
            if (start_in_prime && shifts >= 90 && shifts < 93) begin
                bus.start       = 1'b1;
                bus.num_windows = CNT_W'(nwin + 2);
            end else begin
                bus.start = 1'b0;
            end
            #1;
            total++;
            if (bus.px_ready !== 1'b1 || bus.buf_shift !== bus.px_valid ||
                (bus.px_valid && bus.buf_data !== bus.px_data) || bus.acc_en !== 1'b0) begin
                bad++;
                $display("FAIL prime_path: pr=%b shift=%b valid=%b data=%h want %h at px %0d",
                         bus.px_ready, bus.buf_shift, bus.px_valid, bus.buf_data,
                         bus.px_data, shifts);
                break;
            end
            if (bus.px_valid) shifts++;
            tick();
            cyc++;
        end
        bus.start    = 1'b0;
        bus.px_valid = 1'b0;
        total++;
        if (shifts != PRIME_PX || (!gaps && cyc != PRIME_PX)) begin
            bad++;
            $display("FAIL prime_count: shifts=%0d cycles=%0d want %0d", shifts, cyc, PRIME_PX);
        end

        if (nwin == 0) begin
            #1;
            total++;
            if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.acc_en !== 1'b0) begin
                bad++;
                $display("FAIL zero_done: done=%b ov=%b ae=%b want 1,0,0",
                         bus.done, bus.out_valid, bus.acc_en);
            end
            tick();
            total++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL zero_idle: done=%b busy=%b want 0,0", bus.done, bus.busy);
            end
            return;
        end

        wcyc = 0; prev_hs = 0;
        for (int w = 0; w < nwin; w++) begin
            // FETCH
            got = 1'b0; cyc = 0;
            while (!got && cyc < 200) begin
                bus.px_valid = gaps ? ($urandom_range(0, 1) != 0) : 1'b1;
                bus.px_data  = 24'($urandom);
                #1;
                total++;
                if (bus.px_ready !== 1'b1 || bus.acc_en !== 1'b0 || bus.out_valid !== 1'b0 ||
                    bus.buf_shift !== bus.px_valid || bus.done !== 1'b0) begin
                    bad++;
                    $display("FAIL fetch: pr=%b ae=%b ov=%b shift=%b done=%b window %0d",
                             bus.px_ready, bus.acc_en, bus.out_valid, bus.buf_shift,
                             bus.done, w);
                    break;
                end
                got = bus.px_valid;
                tick();
                wcyc++;
                cyc++;
            end
            bus.px_valid = 1'b1;
            // SWEEP
            for (int t = 0; t < TAPS; t++) begin
                bus.out_ready = 1'b1;
                #1;
                total++;
                if (bus.acc_en !== 1'b1 || bus.tap_idx !== TAP_W'(t) ||
                    bus.select_idx !== SEL_W'(t % KW) || bus.conv_val !== kern[t] ||
                    bus.acc_clear !== (t == 0) || bus.px_ready !== 1'b0 ||
                    bus.buf_shift !== 1'b0 || bus.out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL sweep: w=%0d t=%0d tap=%0d sel=%0d cv=%0d clr=%b ae=%b want tap=%0d sel=%0d cv=%0d clr=%b",
                             w, t, bus.tap_idx, bus.select_idx, bus.conv_val, bus.acc_clear,
                             bus.acc_en, t, t % KW, kern[t], (t == 0));
                end
                tick();
                wcyc++;
            end
            // OUT with optional backpressure
            for (int s = 0; s < stall; s++) begin
                bus.out_ready = 1'b0;
                #1;
                total++;
                if (bus.out_valid !== 1'b1 || bus.px_ready !== 1'b0 || bus.buf_shift !== 1'b0 ||
                    bus.acc_en !== 1'b0 || bus.tap_idx !== '0) begin
                    bad++;
                    $display("FAIL out_hold: ov=%b pr=%b shift=%b ae=%b tap=%0d stall %0d",
                             bus.out_valid, bus.px_ready, bus.buf_shift, bus.acc_en,
                             bus.tap_idx, s);
                end
                tick();
                wcyc++;
            end
            bus.out_ready = 1'b1;
            #1;
            total++;
            if (bus.out_valid !== 1'b1 || bus.px_ready !== 1'b0) begin
                bad++;
                $display("FAIL out_valid: ov=%b pr=%b want 1,0 window %0d",
                         bus.out_valid, bus.px_ready, w);
            end
            if (!gaps && stall == 0 && w > 0) begin
                total++;
                if (wcyc - prev_hs != 27) begin
                    bad++;
                    $display("FAIL window_period: got %0d want 27", wcyc - prev_hs);
                end
            end
            prev_hs = wcyc;
            tick();
            wcyc++;
            bus.out_ready = 1'b0;
            bus.px_valid  = 1'b0;
        end

        #1;
        total++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.px_ready !== 1'b0) begin
            bad++;
            $display("FAIL job_done: done=%b busy=%b ov=%b pr=%b want 1,1,0,0",
                     bus.done, bus.busy, bus.out_valid, bus.px_ready);
        end
        tick();
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL job_idle: done=%b busy=%b want 0,0", bus.done, bus.busy);
        end
    endtask

    task automatic test_kernel_load();
        run_job(1, 1'b1, 0, 1'b0, 1'b1);
    endtask

    task automatic test_three_windows();
        run_job(3, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_job(2, 1'b0, 10, 1'b0, 1'b0);
    endtask

    task automatic test_zero_windows();
        run_job(0, 1'b1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_start_in_prime();
        run_job(2, 1'b1, 0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_sweep();
        bus.start       = 1'b1;
        bus.num_windows = CNT_W'(2);
        tick();
        bus.start       = 1'b0;
        bus.kcoef_valid = 1'b1;
        bus.kcoef_data  = DATA_W'($urandom);
        repeat (TAPS) tick();
        bus.kcoef_valid = 1'b0;
        bus.px_valid    = 1'b1;
        repeat (PRIME_PX + 1) tick();
        bus.px_valid    = 1'b0;
        repeat (12) tick();
        #1;
        total++;
        if (bus.tap_idx !== TAP_W'(12) || bus.acc_en !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_tap: tap=%0d ae=%b want 12,1", bus.tap_idx, bus.acc_en);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.acc_en !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.tap_idx !== '0 || bus.kcoef_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: busy=%b ae=%b ov=%b tap=%0d kr=%b want all 0",
                     bus.busy, bus.acc_en, bus.out_valid, bus.tap_idx, bus.kcoef_ready);
        end
        bus.out_ready = 1'b1;
        repeat (30) tick();
        total++;
        if (bus.out_valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle: ov=%b done=%b busy=%b want 0,0,0",
                     bus.out_valid, bus.done, bus.busy);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random_jobs();
        for (int j = 0; j < 3; j++) begin
            run_job($urandom_range(1, 3), 1'b1, $urandom_range(0, 4), 1'b0, 1'b0);
        end
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.num_windows  = '0;
        bus.kcoef_valid  = 1'b0;
        bus.kcoef_data   = '0;
        bus.px_valid     = 1'b0;
        bus.px_data      = '0;
        bus.out_ready    = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        test_reset();
        test_kernel_load();
        test_three_windows();
        test_backpressure();
        test_zero_windows();
        test_start_in_prime();
        test_reset_mid_sweep();
        test_random_jobs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_sequencer.md
Name: conv_sequencer

Overview:
- Controller that sequences the 5x5, 3-channel convolution datapath: loads the 25-entry kernel coefficient bank, primes the line buffers, then runs one 25-cycle tap sweep per output window.
- Drives tap index, row select, coefficient value and accumulator strobes to the conv channels.
- Sits between the DDR read stream (pixel source) and the DDR write shift register (result sink), and owns all handshakes with both.

Parameters:
- TAPS, 25, coefficients per kernel (KW*KW)
- KW, 5, kernel width; select_idx wraps at KW
- LINE_W, 45, line-buffer depth in pixels
- DATA_W, 8, coefficient and channel width
- CNT_W, 16, width of window counter

Ports:
- CLK  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a job when idle
- num_windows  in  CNT_W  output windows in job; sampled on accepted start
- kcoef_valid  in  1  coefficient stream valid
- kcoef_data  in  DATA_W  coefficient value, order tap 0..24
- kcoef_ready  out  1  sequencer accepts coefficient
- px_valid  in  1  pixel stream valid (from DDR read)
- px_data  in  3*DATA_W  RGB pixel
- px_ready  out  1  sequencer accepts pixel
- buf_shift  out  1  line-buffer shift enable
- buf_data  out  3*DATA_W  pixel into line buffers
- tap_idx  out  5  current tap 0..24
- select_idx  out  3  row select, tap_idx mod KW
- conv_val  out  DATA_W  kernel[tap_idx]
- acc_clear  out  1  clear accumulators (first tap)
- acc_en  out  1  accumulate this cycle
- out_valid  out  1  window result ready for DDR shift register
- out_ready  in  1  sink accepts result
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle pulse at job end

Behaviour:
- Reset: state IDLE; kernel regs, counters and all outputs 0. Reset mid-job aborts immediately; no partial result is emitted.
- States: IDLE, LOAD, PRIME, FETCH, SWEEP, OUT, FIN.
- IDLE: start=1 -> latch num_windows, go LOAD. start in any other state is ignored.
- LOAD: kcoef_ready=1. Each kcoef_valid&kcoef_ready writes kernel[k], k++. On the 25th handshake go PRIME.
- PRIME: px_ready=1. Accept (KW-1)*LINE_W = 180 pixels. If num_windows==0 after the last pixel, go FIN; else go FETCH.
- Pixel path in PRIME and FETCH: buf_data = px_data; buf_shift = px_valid & px_ready (combinational). These are the only combinational input->output paths.
- FETCH: px_ready=1. On handshake go SWEEP with tap=0.
- SWEEP: exactly 25 cycles, one per tap, no stalls.
  - tap_idx = t; select_idx = t mod 5; conv_val = kernel[t]; acc_en=1; acc_clear=1 only at t=0.
  - After t=24 go OUT.
- OUT: out_valid=1, held with tap outputs 0 until out_ready.
  - On handshake, remaining--.
  - remaining==0 -> FIN; else -> FETCH.
- FIN: done=1 for one cycle, then IDLE. busy=0 only in IDLE.
- Per-window latency with no backpressure: 1 FETCH + 25 SWEEP + 1 OUT = 27 cycles, i.e. pixel handshake to out_valid is 26 cycles.
- ready outputs are 0 outside their states. A valid arriving in another state is not consumed.
- tap_idx, select_idx, conv_val, acc_* and out_valid are decoded from registered state/counters only.
- Counters saturate-free: tap wraps 24->0 only on the SWEEP->OUT exit; select wraps 4->0.

Decomposition:
- Package conv_pkg holds:
  - constants TAPS, KW, LINE_W, PRIME_PX=(KW-1)*LINE_W
  - typedef coef_t (logic [DATA_W-1:0])
  - typedef pixel_t (logic [2:0][DATA_W-1:0])
  - enum seq_state_t
- One sub-module, tap_counter: tap 0..24 with mod-5 select; inputs clear and advance; outputs tap_idx, select_idx, last.

Test Plan:
- Reset mid-SWEEP (tap=12) -> next cycle state IDLE, busy=0, acc_en=0, out_valid=0; a fresh start then reloads all 25 coefficients.
- Kernel load with coefficients 1..25 and random kcoef_valid gaps -> kcoef_ready drops after exactly 25 handshakes; in SWEEP, conv_val at tap t equals t+1.
- num_windows=3, px_valid always 1, out_ready always 1 -> 180 PRIME shifts; three 27-cycle windows; acc_clear exactly once per window; done pulses one cycle after the 3rd out handshake.
- out_ready held 0 for 10 cycles in OUT -> out_valid stays 1; px_ready=0 and buf_shift=0 throughout; after the handshake FETCH follows next cycle.
- num_windows=0 -> load and prime complete, then done with no SWEEP cycles and no out_valid.
- start pulsed during PRIME -> ignored; num_windows unchanged; job completes with the originally latched count.
